cnn_div_seq_23s_9s: RTL and testbench

//  Multi-cycle signed restoring divider: the inverse of the 14s x 9s -> 23s product multiplier.

---
 rtl/cnn_div_seq_23s_9s.sv | 155 +++++++++++++++
 tb/tb_cnn_div_seq_23s_9s.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_div_seq_23s_9s.sv
// Multi-cycle signed restoring divider (23s / 9s -> 14s, saturating), one op in flight.
// Optional remainder output enabled by defining CNN_DIV_REMAINDER_EN.
module cnn_div_seq_23s_9s #(
  parameter int DIVIDEND_W = 23,
  parameter int DIVISOR_W  = 9,
  parameter int QUOT_W     = 14
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOT_W-1:0]     quotient,
  output logic                         ovf,
  output logic                         div_by_zero
`ifdef CNN_DIV_REMAINDER_EN
  ,
  output logic signed [DIVISOR_W-1:0]  remainder
`endif
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [DIVIDEND_W-1:0]   QPOS_MAG = DIVIDEND_W'((2**(QUOT_W-1)) - 1);
  localparam logic [DIVIDEND_W-1:0]   QNEG_MAG = DIVIDEND_W'(2**(QUOT_W-1));
  localparam logic signed [QUOT_W-1:0] QMAX    = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic signed [QUOT_W-1:0] QMIN    = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // q_mag shifts dividend bits out at the top and quotient bits in at the bottom
  logic [DIVIDEND_W-1:0] q_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic [DIVISOR_W-1:0]  rem_mag;
  logic                  dvd_neg;
  logic                  quo_neg;

  logic [DIVISOR_W:0]    rem_sh;
  logic                  rem_ge;
  logic [DIVISOR_W-1:0]  rem_nxt;

  // Unsigned magnitude; the two's-complement negate of the most negative value
  // lands on 2^(W-1), which the unsigned register holds exactly.
  function automatic logic [DIVIDEND_W-1:0] abs_dvd(input logic signed [DIVIDEND_W-1:0] x);
    logic [DIVIDEND_W-1:0] u;
    u = x;
    return x[DIVIDEND_W-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [DIVISOR_W-1:0] abs_dvs(input logic signed [DIVISOR_W-1:0] x);
    logic [DIVISOR_W-1:0] u;
    u = x;
    return x[DIVISOR_W-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic sat_ovf(input logic neg, input logic [DIVIDEND_W-1:0] mag);
    return neg ? (mag > QNEG_MAG) : (mag > QPOS_MAG);
  endfunction

  function automatic logic signed [QUOT_W-1:0] sat_quot(input logic neg,
                                                        input logic [DIVIDEND_W-1:0] mag);
    logic [QUOT_W-1:0] t;
    t = mag[QUOT_W-1:0];
    if (!neg && (mag > QPOS_MAG)) return QMAX;
    if (neg && (mag > QNEG_MAG))  return QMIN;
    return neg ? signed'(~t + 1'b1) : signed'(t);
  endfunction

  assign accept = in_valid && in_ready;

  // Restoring step: partial remainder < divisor <= 2^(DIVISOR_W-1), so the shifted value fits DIVISOR_W+1 bits
  always_comb begin
    rem_sh  = {rem_mag, q_mag[DIVIDEND_W-1]};
    rem_ge  = rem_sh >= {1'b0, dvs_mag};
    rem_nxt = rem_ge ? DIVISOR_W'(rem_sh - {1'b0, dvs_mag}) : DIVISOR_W'(rem_sh);
  end

  always_ff @(posedge ap_clk) begin
    if (accept) begin
      q_mag   <= abs_dvd(dividend);
      dvs_mag <= abs_dvs(divisor);
      rem_mag <= '0;
      dvd_neg <= dividend[DIVIDEND_W-1];
      quo_neg <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
    end else if (state == CALC) begin
      q_mag   <= {q_mag[DIVIDEND_W-2:0], rem_ge};
      rem_mag <= rem_nxt;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef CNN_DIV_REMAINDER_EN
      remainder   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= CALC;
            cnt         <= CNT_W'(DIVIDEND_W - 1);
            in_ready    <= 1'b0;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        // Sign fix-up and saturation into the output registers
        FIX: begin
          if (dvs_mag == '0) begin
            quotient    <= dvd_neg ? QMIN : QMAX;
            ovf         <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= sat_quot(quo_neg, q_mag);
            ovf         <= sat_ovf(quo_neg, q_mag);
            div_by_zero <= 1'b0;
          end
`ifdef CNN_DIV_REMAINDER_EN
          if (dvs_mag == '0)  remainder <= '0;
          else if (dvd_neg)   remainder <= signed'(~rem_mag + 1'b1);
          else                remainder <= signed'(rem_mag);
`endif
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_div_seq_23s_9s.sv
// Scoreboard bench for cnn_div_seq_23s_9s: directed corner cases, backpressure, reset abort,
// random round-trip and general random operations against an arithmetic reference model.
module tb_cnn_div_seq_23s_9s;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [22:0] dividend = '0;
  logic signed [8:0]  divisor = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [13:0] quotient;
  logic               ovf;
  logic               div_by_zero;
`ifdef CNN_DIV_REMAINDER_EN
  logic signed [8:0]  remainder;
`endif

  cnn_div_seq_23s_9s dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .ovf         (ovf),
    .div_by_zero (div_by_zero)
`ifdef CNN_DIV_REMAINDER_EN
    ,
    .remainder   (remainder)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct {
    longint q;
    logic   ovf;
    logic   dbz;
    longint r;
    int     acc;
    longint a;
    longint b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rnd_bp = 1'b0;

  function automatic void check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Reference: SV integer division truncates toward zero and % follows the dividend's sign
  function automatic exp_t model(input longint a, input longint b);
    exp_t   e;
    longint qt;
    e.a = a; e.b = b; e.acc = 0;
    if (b == 0) begin
      e.q = (a >= 0) ? 8191 : -8192;
      e.ovf = 1'b0; e.dbz = 1'b1; e.r = 0;
    end else begin
      qt = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      e.q = qt;
      if (qt > 8191) begin e.q = 8191; e.ovf = 1'b1; end
      else if (qt < -8192) begin e.q = -8192; e.ovf = 1'b1; end
    end
    return e;
  endfunction

  // Monitor: latency at rising out_valid, stability while stalled, pop and compare at handshake
  logic               prev_ov = 1'b0;
  logic               prev_rdy = 1'b0;
  logic signed [13:0] prev_q = '0;
  logic               prev_ovf = 1'b0;
  logic               prev_dbz = 1'b0;
  exp_t               me;

  always @(negedge ap_clk) begin
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) check("spurious_out_valid", 1, 0);
      else check($sformatf("latency(%0d/%0d)", sb[0].a, sb[0].b), cyc - sb[0].acc, 24);
    end
    if (out_valid && prev_ov && !prev_rdy) begin
      check("hold_quotient", quotient, prev_q);
      check("hold_ovf", ovf, prev_ovf);
      check("hold_dbz", div_by_zero, prev_dbz);
      check("hold_in_ready", in_ready, 0);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        me = sb.pop_front();
        check($sformatf("q(%0d/%0d)", me.a, me.b), quotient, me.q);
        check($sformatf("ovf(%0d/%0d)", me.a, me.b), ovf, me.ovf);
        check($sformatf("dbz(%0d/%0d)", me.a, me.b), div_by_zero, me.dbz);
`ifdef CNN_DIV_REMAINDER_EN
        check($sformatf("rem(%0d/%0d)", me.a, me.b), remainder, me.r);
`endif
      end
    end
    prev_ov  = out_valid;
    prev_rdy = out_ready;
    prev_q   = quotient;
    prev_ovf = ovf;
    prev_dbz = div_by_zero;
  end

  // Random backpressure, changed away from both clock edges' sampling points
  always @(posedge ap_clk) begin
    if (rnd_bp) begin
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d outstanding, expected 0", sb.size());
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input longint a, input longint b);
    exp_t e;
    int   w;
    dividend = 23'(a);
    divisor  = 9'(b);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge ap_clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge ap_clk);
    in_valid = 1'b0;
    e = model(a, b);
    e.acc = cyc;
    sb.push_back(e);
    check("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 400) begin
      @(negedge ap_clk);
      w++;
    end
    check("drain_outstanding", sb.size(), 0);
  endtask

  task automatic wait_out_valid();
    int w;
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge ap_clk);
      w++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  longint dir_a[9] = '{1000, -1000, 1000, -1000, 4194303, -4194304, -4194304, 500, -500};
  longint dir_b[9] = '{7, 7, -7, -7, 1, -1, 1, 0, 0};

  initial begin
    logic signed [22:0] rd;
    logic signed [8:0]  rs;
    longint             a;
    longint             b;

    // Reset state
    repeat (3) @(negedge ap_clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dbz", div_by_zero, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Directed corner cases
    for (int i = 0; i < 9; i++) issue(dir_a[i], dir_b[i]);
    drain();

    // Backpressure: result held for 10 stalled cycles, then handshake
    out_ready = 1'b0;
    issue(1000, 7);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge ap_clk);
    #1 out_ready = 1'b1;
    @(negedge ap_clk);
    check("bp_handshake_in_ready", in_ready, 0);
    @(negedge ap_clk);
    check("bp_after_out_valid", out_valid, 0);
    check("bp_after_in_ready", in_ready, 1);
    drain();

    // Reset during CALC aborts the operation
    issue(5000, 3);
    repeat (11) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_calc_out_valid", out_valid, 0);
    check("abort_calc_in_ready", in_ready, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("abort_calc_release_in_ready", in_ready, 1);
    issue(84, 4);
    drain();

    // Reset while a result is being presented drops out_valid at once
    out_ready = 1'b0;
    issue(-1000, 7);
    wait_out_valid();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_done_out_valid", out_valid, 0);
    check("abort_done_quotient", quotient, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge ap_clk);
    check("abort_done_release_in_ready", in_ready, 1);

    // Random round trip and general random operations under random backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = longint'($urandom_range(0, 16383)) - 8192;
      do b = longint'($urandom_range(0, 511)) - 256; while (b == 0);
      issue(a * b, b);
    end
    for (int i = 0; i < 200; i++) begin
      rd = 23'($urandom);
      rs = 9'($urandom);
      a = rd;
      b = ($urandom_range(0, 7) == 0) ? 0 : rs;
      issue(a, b);
    end
    rnd_bp = 1'b0;
    @(posedge ap_clk);
    #2 out_ready = 1'b1;
    @(negedge ap_clk);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
